lut_digit_serial_mult: RTL and testbench
========================================

// Module: lut_digit_serial_mult
// PURPOSE
//  Sequential WIDTH x WIDTH unsigned multiplier built around one 2x2 LUT multiplier.
//  Each operand is split into 2-bit digits; one digit-pair partial product is formed per cycle,
//  shifted and accumulated. Sits downstream of the 2x2 LUT stage and consumes its 4-bit product.
//  Valid/ready handshake on both sides for use in MultiplierLUT testcase pipelines.
// PARAMETERS
//  WIDTH   8   operand width in bits; must be even and >= 2; elaboration error otherwise
//  D       WIDTH/2 (localparam)   digits per operand; one operation takes D*D RUN cycles
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        operands a/b valid
//  in_ready   out  1        block can accept operands
//  a          in   WIDTH    unsigned multiplicand
//  b          in   WIDTH    unsigned multiplier
//  out_valid  out  1        product valid
//  out_ready  in   1        consumer accepts product
//  product    out  2*WIDTH  unsigned a*b
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, acc=0, product=0, out_valid=0,
//    digit counters=0, in_ready=0 while rst high.
//  - FSM: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after D*D RUN cycles;
//    DONE -> IDLE on out_valid&&out_ready.
//  - in_ready = (state==IDLE) && !rst. Operands are captured into a_q/b_q on the accepting edge.
//    acc and both counters clear on that same edge.
//  - RUN, each edge: pp = lut(a_q[2i+1:2i], b_q[2j+1:2j]) (4 bits).
//    acc <= acc + (pp << 2*(i+j)). j increments; when j wraps D-1->0, i increments.
//    The edge with i=j=D-1 moves to DONE and loads product <= final acc.
//  - Latency: out_valid is high exactly D*D cycles after the accepting edge (WIDTH=8: 16).
//  - acc is 2*WIDTH wide. The maximum sum equals (2^WIDTH-1)^2 and never overflows.
//    The shift is zero-extended.
//  - DONE: out_valid=1; product stable. Backpressure (out_ready=0) holds DONE indefinitely.
//    In this state in_ready=0 and input changes are ignored.
//  - After the output handshake: IDLE on the next edge, in_ready=1.
//    Back-to-back throughput is one result per D*D+2 cycles; no overlap of operations.
//  - product holds its last value outside DONE (only reloaded on DONE entry).
//  - a/b changes during RUN have no effect (captured copies are used).
//  - rst during RUN or DONE aborts the operation: no out_valid pulse, partial acc discarded.
//    The first operation after release is correct.
//  - in_valid while not in_ready: ignored. No loss of the held request; the source keeps
//    in_valid high until it sees in_ready.
//  - No X propagation: all flops reset. The LUT output is defined for all 16 digit combinations.
// STRUCTURE
//  - lut_mult_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} lut_mult_state_t;
//    localparam DIGIT_W=2, PP_W=4.
//  - Sub-module lut_mult_2x2: purely combinational 2-bit x 2-bit -> 4-bit table; one instance.
//  - Top: FSM, operand regs, digit counters ($clog2(D) bits, min 1), digit muxes,
//    barrel shift, accumulator, product reg.
// TESTING
//  1. rst 3 cycles, release; a=0,b=0 accepted -> out_valid after 16 cycles, product=16'h0000.
//  2. a=8'hFF,b=8'hFF -> product=16'hFE01, out_valid exactly 16 cycles after accept.
//  3. a=8'd13,b=8'd11, out_ready low 5 cycles in DONE -> product=143 held stable;
//     in_ready=0 throughout; single handshake.
//  4. in_valid held high with a=2,b=3 then a=200,b=100 -> second op accepted the cycle after
//     the first output handshake; products 6 then 20000.
//  5. Start a=8'hAA,b=8'h55, assert rst on RUN cycle 7 -> out_valid stays 0, product=0.
//     After release a=7,b=9 -> 63.
//  6. 1000 random a/b with random out_ready -> compare vs a*b golden model, mismatch count must be 0.
//     Repeat with WIDTH=2 (1 RUN cycle) and WIDTH=16.

Source files
------------

// File: rtl/lut_mult_pkg.sv
// Shared types and constants for the LUT-based digit-serial multiplier.
//   lut_mult_state_t : control FSM state encoding
//   DIGIT_W          : operand digit width fed to the 2x2 LUT
//   PP_W             : width of one LUT partial product
package lut_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} lut_mult_state_t;

    localparam int unsigned DIGIT_W = 2;
    localparam int unsigned PP_W    = 4;

endpackage

// File: rtl/lut_mult_2x2.sv
// Purely combinational 2-bit x 2-bit unsigned multiplier implemented as a lookup table.
// Ports:
//   x : multiplicand digit (DIGIT_W bits)
//   y : multiplier digit   (DIGIT_W bits)
//   p : product            (PP_W bits), defined for all 16 input combinations
module lut_mult_2x2
    import lut_mult_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    output logic [PP_W-1:0]    p
);

    always_comb begin
        p = '0;
        case ({x, y})
            4'b00_00: p = 4'd0;
            4'b00_01: p = 4'd0;
            4'b00_10: p = 4'd0;
            4'b00_11: p = 4'd0;
            4'b01_00: p = 4'd0;
            4'b01_01: p = 4'd1;
            4'b01_10: p = 4'd2;
            4'b01_11: p = 4'd3;
            4'b10_00: p = 4'd0;
            4'b10_01: p = 4'd2;
            4'b10_10: p = 4'd4;
            4'b10_11: p = 4'd6;
            4'b11_00: p = 4'd0;
            4'b11_01: p = 4'd3;
            4'b11_10: p = 4'd6;
            4'b11_11: p = 4'd9;
        endcase
    end

endmodule

// File: rtl/lut_digit_serial_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier. Operands are split into 2-bit digits and one
// digit-pair partial product (from a single 2x2 LUT) is shifted and accumulated per cycle.
// One operation takes D*D RUN cycles, D = WIDTH/2.
// Ports:
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : operand handshake; a, b captured on the accepting edge
//   a, b                 : unsigned operands (WIDTH bits)
//   out_valid / out_ready: result handshake; product held stable while out_valid is high
//   product              : unsigned a*b (2*WIDTH bits)
module lut_digit_serial_mult
    import lut_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned D  = WIDTH / 2;
    localparam int unsigned CW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    generate
        if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
            $error("lut_digit_serial_mult: WIDTH must be even and >= 2");
        end
    endgenerate

    lut_mult_state_t state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [PW-1:0]    acc;
    logic [CW-1:0]    di;
    logic [CW-1:0]    dj;

    logic [DIGIT_W-1:0] a_dig;
    logic [DIGIT_W-1:0] b_dig;
    logic [PP_W-1:0]    pp;
    logic [PW-1:0]      pp_shift;
    logic [PW-1:0]      acc_next;
    int unsigned        shamt;
    logic               last_i;
    logic               last_j;

    // rst gates in_ready directly so nothing is accepted while reset is held.
    assign in_ready = (state == IDLE) && !rst;

    always_comb begin
        a_dig    = a_q[DIGIT_W*32'(di) +: DIGIT_W];
        b_dig    = b_q[DIGIT_W*32'(dj) +: DIGIT_W];
        shamt    = DIGIT_W * (32'(di) + 32'(dj));
        pp_shift = PW'(pp) << shamt;
        acc_next = acc + pp_shift;
        last_i   = (di == CW'(D - 1));
        last_j   = (dj == CW'(D - 1));
    end

    lut_mult_2x2 u_lut (
        .x (a_dig),
        .y (b_dig),
        .p (pp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            di        <= '0;
            dj        <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= a;
                        b_q   <= b;
                        acc   <= '0;
                        di    <= '0;
                        dj    <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    if (last_j) begin
                        dj <= '0;
                        if (last_i) begin
                            // Final digit pair: publish the completed sum directly.
                            product   <= acc_next;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            di <= di + CW'(1);
                        end
                    end else begin
                        dj <= dj + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_digit_serial_mult.sv
// Self-checking bench for lut_digit_serial_mult: directed scenarios on a WIDTH=8 instance plus
// randomized scoreboard runs on WIDTH=8, WIDTH=2 and WIDTH=16 instances.
module tb_lut_digit_serial_mult;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  a, b;
    logic [15:0] product;
    logic [15:0] q8[$];

    // WIDTH=2 instance
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [1:0]  s_a, s_b;
    logic [3:0]  s_product;
    logic [3:0]  q2[$];

    // WIDTH=16 instance
    logic        l_in_valid, l_in_ready, l_out_valid, l_out_ready;
    logic [15:0] l_a, l_b;
    logic [31:0] l_product;
    logic [31:0] q16[$];

    lut_digit_serial_mult #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .product(product)
    );

    lut_digit_serial_mult #(.WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .product(s_product)
    );

    lut_digit_serial_mult #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst(rst), .in_valid(l_in_valid), .in_ready(l_in_ready), .a(l_a), .b(l_b),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .product(l_product)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive operands until the accepting edge has passed; returns at accept edge + 1.
    task automatic accept(input logic [7:0] aa, input logic [7:0] bb);
        int n = 0;
        a = aa; b = bb; in_valid = 1'b1;
        while (!in_ready && n < 200) begin tick(); n++; end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin tick(); cyc++; end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 0; a = '0; b = '0;
        s_in_valid = 0; s_out_ready = 0; s_a = '0; s_b = '0;
        l_in_valid = 0; l_out_ready = 0; l_a = '0; l_b = '0;
        repeat (3) tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (product !== 16'h0) begin bad++; $display("FAIL rst_product got=%h exp=0000", product); end
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
        tick();
    endtask

    task automatic test_latency();
        logic [7:0]  pa [2] = '{8'h00, 8'hFF};
        logic [7:0]  pb [2] = '{8'h00, 8'hFF};
        logic [15:0] exp;
        int cyc;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            accept(pa[k], pb[k]);
            q8.push_back(16'(pa[k]) * 16'(pb[k]));
            wait_out(cyc);
            total++; if (cyc != 16) begin bad++; $display("FAIL latency_%0d got=%0d exp=16", k, cyc); end
            exp = q8.pop_front();
            total++; if (product !== exp) begin bad++; $display("FAIL product_%0d got=%h exp=%h", k, product, exp); end
            tick();
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL after_hs_%0d out_valid=%b in_ready=%b exp 0/1", k, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp;
        int cyc;
        logic seen = 1'b0;
        out_ready = 1'b0;
        accept(8'd13, 8'd11);
        q8.push_back(16'd143);
        wait_out(cyc);
        in_valid = 1'b1; a = 8'd5; b = 8'd5;
        for (int k = 0; k < 5; k++) begin
            total++; if (product !== 16'd143 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL hold_%0d product=%0d in_ready=%b out_valid=%b exp 143/0/1",
                                k, product, in_ready, out_valid);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        exp = q8.pop_front();
        total++; if (product !== exp) begin bad++; $display("FAIL bp_product got=%0d exp=%0d", product, exp); end
        tick();
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL bp_single_hs got=repeat_valid exp=none"); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp;
        int cyc;
        out_ready = 1'b1;
        accept(8'd2, 8'd3);
        q8.push_back(16'd6);
        // Keep the request up with new operands; the in-flight op must ignore them.
        in_valid = 1'b1; a = 8'd200; b = 8'd100;
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL b2b_latency1 got=%0d exp=16", cyc); end
        exp = q8.pop_front();
        total++; if (product !== exp) begin bad++; $display("FAIL b2b_product1 got=%0d exp=%0d", product, exp); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        q8.push_back(16'd20000);
        tick();
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_accept2 in_ready=%b exp=0", in_ready); end
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL b2b_latency2 got=%0d exp=16", cyc); end
        exp = q8.pop_front();
        total++; if (product !== exp) begin bad++; $display("FAIL b2b_product2 got=%0d exp=%0d", product, exp); end
        tick();
    endtask

    task automatic test_reset_abort();
        logic [15:0] exp;
        int cyc;
        logic seen = 1'b0;
        out_ready = 1'b1;
        accept(8'hAA, 8'h55);
        repeat (6) tick();
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL abort_rst in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid);
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_valid got=pulse exp=none"); end
        total++; if (product !== 16'h0) begin bad++; $display("FAIL abort_product got=%h exp=0000", product); end
        accept(8'd7, 8'd9);
        q8.push_back(16'd63);
        wait_out(cyc);
        total++; if (cyc != 16) begin bad++; $display("FAIL abort_latency got=%0d exp=16", cyc); end
        exp = q8.pop_front();
        total++; if (product !== exp) begin bad++; $display("FAIL abort_product2 got=%0d exp=%0d", product, exp); end
        tick();
    endtask

    task automatic test_random_w8(input int num);
        fork
            begin
                for (int k = 0; k < num; k++) begin
                    logic [7:0] ra, rb;
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    repeat ($urandom_range(0, 2)) tick();
                    accept(ra, rb);
                    q8.push_back(16'(ra) * 16'(rb));
                end
            end
            begin
                int got = 0;
                int guard = 0;
                logic [15:0] exp;
                while (got < num && guard < num * 60) begin
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        exp = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
                        total++;
                        if (product !== exp) begin
                            bad++; $display("FAIL rand_w8 got=%h exp=%h", product, exp);
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                total++;
                if (got != num) begin bad++; $display("FAIL rand_w8_timeout got=%0d exp=%0d", got, num); end
            end
        join
        out_ready = 1'b1;
    endtask

    task automatic test_random_w2(input int num);
        fork
            begin
                for (int k = 0; k < num; k++) begin
                    int n = 0;
                    s_a = 2'($urandom);
                    s_b = 2'($urandom);
                    s_in_valid = 1'b1;
                    while (!s_in_ready && n < 100) begin tick(); n++; end
                    total++;
                    if (s_in_ready !== 1'b1) begin bad++; $display("FAIL rand_w2_accept ready=%b exp=1", s_in_ready); end
                    q2.push_back(4'(s_a) * 4'(s_b));
                    tick();
                    s_in_valid = 1'b0;
                end
            end
            begin
                int got = 0;
                int guard = 0;
                logic [3:0] exp;
                while (got < num && guard < num * 60) begin
                    s_out_ready = 1'($urandom_range(0, 1));
                    if (s_out_valid && s_out_ready) begin
                        exp = (q2.size() > 0) ? q2.pop_front() : 4'hx;
                        total++;
                        if (s_product !== exp) begin
                            bad++; $display("FAIL rand_w2 got=%h exp=%h", s_product, exp);
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                total++;
                if (got != num) begin bad++; $display("FAIL rand_w2_timeout got=%0d exp=%0d", got, num); end
            end
        join
    endtask

    task automatic test_random_w16(input int num);
        fork
            begin
                for (int k = 0; k < num; k++) begin
                    int n = 0;
                    l_a = 16'($urandom);
                    l_b = 16'($urandom);
                    if (k == 0) begin l_a = 16'hFFFF; l_b = 16'hFFFF; end
                    l_in_valid = 1'b1;
                    while (!l_in_ready && n < 300) begin tick(); n++; end
                    total++;
                    if (l_in_ready !== 1'b1) begin bad++; $display("FAIL rand_w16_accept ready=%b exp=1", l_in_ready); end
                    q16.push_back(32'(l_a) * 32'(l_b));
                    tick();
                    l_in_valid = 1'b0;
                end
            end
            begin
                int got = 0;
                int guard = 0;
                logic [31:0] exp;
                while (got < num && guard < num * 200) begin
                    l_out_ready = 1'($urandom_range(0, 1));
                    if (l_out_valid && l_out_ready) begin
                        exp = (q16.size() > 0) ? q16.pop_front() : 32'hxxxx_xxxx;
                        total++;
                        if (l_product !== exp) begin
                            bad++; $display("FAIL rand_w16 got=%h exp=%h", l_product, exp);
                        end
                        got++;
                    end
                    tick();
                    guard++;
                end
                total++;
                if (got != num) begin bad++; $display("FAIL rand_w16_timeout got=%0d exp=%0d", got, num); end
            end
        join
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog sim_time_exceeded exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random_w8(1000);
        test_random_w2(300);
        test_random_w16(200);
        total++;
        if (q8.size() != 0 || q2.size() != 0 || q16.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover got=%0d/%0d/%0d exp=0/0/0", q8.size(), q2.size(), q16.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
